// File: rtl/toy_alu_issue_queue.sv
// ALU issue queue: buffers dispatched instructions, captures operands from two
// writeback buses and issues the oldest ready entry to the ALU.
package eu_pkg;
    localparam int PHY_REG_ID_WIDTH = 6;
    localparam int REG_WIDTH        = 32;

    typedef struct packed {
        logic [3:0]                  opcode;
        logic [PHY_REG_ID_WIDTH-1:0] reg_rd_idx;
        logic [REG_WIDTH-1:0]        reg_rs1_val;
        logic [REG_WIDTH-1:0]        reg_rs2_val;
    } eu_pld_t;
endpackage

module toy_alu_issue_queue
    import eu_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enq_vld,
    output logic                        enq_rdy,
    input  eu_pld_t                     enq_pld,
    input  logic                        enq_rs1_rdy,
    input  logic [PHY_REG_ID_WIDTH-1:0] enq_rs1_idx,
    input  logic                        enq_rs2_rdy,
    input  logic [PHY_REG_ID_WIDTH-1:0] enq_rs2_idx,
    input  logic                        wb0_en,
    input  logic [PHY_REG_ID_WIDTH-1:0] wb0_index,
    input  logic [REG_WIDTH-1:0]        wb0_data,
    input  logic                        wb1_en,
    input  logic [PHY_REG_ID_WIDTH-1:0] wb1_index,
    input  logic [REG_WIDTH-1:0]        wb1_data,
    input  logic                        flush,
    output logic                        instruction_vld,
    input  logic                        instruction_rdy,
    output eu_pld_t                     instruction_pld,
    output logic [CNT_WIDTH-1:0]        iq_count,
    output logic                        iq_empty
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        eu_pld_t                     pld;
        logic                        rs1_rdy;
        logic [PHY_REG_ID_WIDTH-1:0] rs1_idx;
        logic                        rs2_rdy;
        logic [PHY_REG_ID_WIDTH-1:0] rs2_idx;
    } entry_t;

    logic [DEPTH-1:0]     vld_q, vld_d;
    entry_t               ent_q [DEPTH];
    entry_t               ent_d [DEPTH];
    entry_t               woken [DEPTH];
    entry_t               enq_raw, enq_ent;
    logic [CNT_WIDTH-1:0] count_q, count_d, enq_pos;
    logic [DEPTH-1:0]     ready_vec;
    logic [IDX_W-1:0]     sel;
    logic                 issue_fire, enq_fire;

    // Operand capture from either writeback bus; wb0 takes precedence on a double hit.
    function automatic entry_t wake(input entry_t e);
        entry_t r;
        r = e;
        if (!e.rs1_rdy) begin
            if (wb0_en && (wb0_index == e.rs1_idx)) begin
                r.rs1_rdy         = 1'b1;
                r.pld.reg_rs1_val = wb0_data;
            end else if (wb1_en && (wb1_index == e.rs1_idx)) begin
                r.rs1_rdy         = 1'b1;
                r.pld.reg_rs1_val = wb1_data;
            end
        end
        if (!e.rs2_rdy) begin
            if (wb0_en && (wb0_index == e.rs2_idx)) begin
                r.rs2_rdy         = 1'b1;
                r.pld.reg_rs2_val = wb0_data;
            end else if (wb1_en && (wb1_index == e.rs2_idx)) begin
                r.rs2_rdy         = 1'b1;
                r.pld.reg_rs2_val = wb1_data;
            end
        end
        return r;
    endfunction

    always_comb begin
        ready_vec = '0;
        sel       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready_vec[i] = vld_q[i] & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
            if (ready_vec[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    assign instruction_vld = |ready_vec;
    assign instruction_pld = ent_q[sel].pld;
    assign enq_rdy         = (count_q < CNT_WIDTH'(DEPTH));
    assign iq_count        = count_q;
    assign iq_empty        = (count_q == '0);

    assign issue_fire = instruction_vld & instruction_rdy;
    assign enq_fire   = enq_vld & enq_rdy & ~flush;
    assign enq_pos    = count_q - CNT_WIDTH'(issue_fire);

    // Incoming instruction also snoops this cycle's writebacks so no tag slips past.
    always_comb begin
        enq_raw.pld     = enq_pld;
        enq_raw.rs1_rdy = enq_rs1_rdy;
        enq_raw.rs1_idx = enq_rs1_idx;
        enq_raw.rs2_rdy = enq_rs2_rdy;
        enq_raw.rs2_idx = enq_rs2_idx;
        enq_ent         = wake(enq_raw);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = wake(ent_q[i]);
        end
    end

    // Compaction: entries above the issued slot move down one, carrying fresh wakeups.
    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = woken[i];
        end
        if (issue_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel) begin
                    vld_d[i] = vld_q[i + 1];
                    ent_d[i] = woken[i + 1];
                end
            end
            vld_d[DEPTH-1] = 1'b0;
        end
        if (enq_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_WIDTH'(i) == enq_pos) begin
                    vld_d[i] = 1'b1;
                    ent_d[i] = enq_ent;
                end
            end
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    always_comb begin
        count_d = count_q + CNT_WIDTH'(enq_fire) - CNT_WIDTH'(issue_fire);
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end

    // Payload storage has no reset; validity is tracked solely by vld_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

endmodule

// File: tb/tb_toy_alu_issue_queue.sv
// Directed bench for toy_alu_issue_queue: expected issues are queued when the
// stimulus is applied and a monitor compares every accepted issue in order.
module tb_toy_alu_issue_queue;
    import eu_pkg::*;

    logic                        clk;
    logic                        rst_n;
    logic                        enq_vld;
    logic                        enq_rdy;
    eu_pld_t                     enq_pld;
    logic                        enq_rs1_rdy;
    logic [PHY_REG_ID_WIDTH-1:0] enq_rs1_idx;
    logic                        enq_rs2_rdy;
    logic [PHY_REG_ID_WIDTH-1:0] enq_rs2_idx;
    logic                        wb0_en;
    logic [PHY_REG_ID_WIDTH-1:0] wb0_index;
    logic [REG_WIDTH-1:0]        wb0_data;
    logic                        wb1_en;
    logic [PHY_REG_ID_WIDTH-1:0] wb1_index;
    logic [REG_WIDTH-1:0]        wb1_data;
    logic                        flush;
    logic                        instruction_vld;
    logic                        instruction_rdy;
    eu_pld_t                     instruction_pld;
    logic [3:0]                  iq_count;
    logic                        iq_empty;

    int      vectors     = 0;
    int      miscompares = 0;
    eu_pld_t expQ[$];

    toy_alu_issue_queue #(.DEPTH(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enq_vld         (enq_vld),
        .enq_rdy         (enq_rdy),
        .enq_pld         (enq_pld),
        .enq_rs1_rdy     (enq_rs1_rdy),
        .enq_rs1_idx     (enq_rs1_idx),
        .enq_rs2_rdy     (enq_rs2_rdy),
        .enq_rs2_idx     (enq_rs2_idx),
        .wb0_en          (wb0_en),
        .wb0_index       (wb0_index),
        .wb0_data        (wb0_data),
        .wb1_en          (wb1_en),
        .wb1_index       (wb1_index),
        .wb1_data        (wb1_data),
        .flush           (flush),
        .instruction_vld (instruction_vld),
        .instruction_rdy (instruction_rdy),
        .instruction_pld (instruction_pld),
        .iq_count        (iq_count),
        .iq_empty        (iq_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic eu_pld_t mkPld(input logic [3:0] opc, input logic [31:0] v1,
                                      input logic [31:0] v2);
        eu_pld_t p;
        p.opcode      = opc;
        p.reg_rd_idx  = {2'b00, opc};
        p.reg_rs1_val = v1;
        p.reg_rs2_val = v2;
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] opc,
                                 input logic r1, input logic [5:0] i1, input logic [31:0] v1,
                                 input logic r2, input logic [5:0] i2, input logic [31:0] v2);
        enq_vld     = 1'b1;
        enq_pld     = mkPld(opc, v1, v2);
        enq_rs1_rdy = r1;
        enq_rs1_idx = i1;
        enq_rs2_rdy = r2;
        enq_rs2_idx = i2;
    endtask

    // Monitor: every accepted issue must match the head of the expected queue.
    initial begin
        eu_pld_t exp;
        forever begin
            @(negedge clk);
            if (rst_n && instruction_vld && instruction_rdy && !flush) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_issue: got opcode 0x%0h, expected no issue",
                             instruction_pld.opcode);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("issue_pld", 128'(instruction_pld), 128'(exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; enq_vld = 1'b0; enq_pld = '0;
        enq_rs1_rdy = 1'b0; enq_rs1_idx = '0; enq_rs2_rdy = 1'b0; enq_rs2_idx = '0;
        wb0_en = 1'b0; wb0_index = '0; wb0_data = '0;
        wb1_en = 1'b0; wb1_index = '0; wb1_data = '0;
        flush = 1'b0; instruction_rdy = 1'b0;

        #12;
        checkOutput("rst_count", 128'(iq_count), 128'(0));
        checkOutput("rst_empty", 128'(iq_empty), 128'(1));
        checkOutput("rst_ivld", 128'(instruction_vld), 128'(0));
        checkOutput("rst_enq_rdy", 128'(enq_rdy), 128'(1));
        #5 rst_n = 1'b1;
        tick();

        // Both sources ready: issues the cycle after enqueue.
        $display("[TB] ready ADD enqueue");
        applyStimulus(4'h1, 1'b1, 6'd1, 32'h5, 1'b1, 6'd2, 32'h3);
        expQ.push_back(mkPld(4'h1, 32'h5, 32'h3));
        tick();
        enq_vld = 1'b0;
        checkOutput("t1_count", 128'(iq_count), 128'(1));
        checkOutput("t1_ivld", 128'(instruction_vld), 128'(1));
        checkOutput("t1_rs1", 128'(instruction_pld.reg_rs1_val), 128'(32'h5));
        instruction_rdy = 1'b1;
        tick();
        checkOutput("t1_count_after", 128'(iq_count), 128'(0));
        checkOutput("t1_empty_after", 128'(iq_empty), 128'(1));
        checkOutput("t1_ivld_after", 128'(instruction_vld), 128'(0));

        // Wakeup on wb1 in cycle N makes the entry issue in N+1.
        $display("[TB] wb1 wakeup");
        applyStimulus(4'h2, 1'b0, 6'd12, 32'h0, 1'b1, 6'd3, 32'h7);
        tick();
        enq_vld = 1'b0;
        checkOutput("t2_wait_ivld", 128'(instruction_vld), 128'(0));
        checkOutput("t2_count", 128'(iq_count), 128'(1));
        wb1_en = 1'b1; wb1_index = 6'd12; wb1_data = 32'hDEADBEEF;
        expQ.push_back(mkPld(4'h2, 32'hDEADBEEF, 32'h7));
        tick();
        wb1_en = 1'b0;
        checkOutput("t2_ivld", 128'(instruction_vld), 128'(1));
        checkOutput("t2_rs1", 128'(instruction_pld.reg_rs1_val), 128'(32'hDEADBEEF));
        tick();
        checkOutput("t2_count_after", 128'(iq_count), 128'(0));

        // Enqueue bypass, both buses hitting the same tag: wb0 data wins.
        $display("[TB] enqueue bypass");
        applyStimulus(4'h3, 1'b1, 6'd4, 32'h11, 1'b0, 6'd7, 32'hBAD);
        wb0_en = 1'b1; wb0_index = 6'd7; wb0_data = 32'h42;
        wb1_en = 1'b1; wb1_index = 6'd7; wb1_data = 32'h99;
        expQ.push_back(mkPld(4'h3, 32'h11, 32'h42));
        tick();
        enq_vld = 1'b0; wb0_en = 1'b0; wb1_en = 1'b0;
        checkOutput("t3_ivld", 128'(instruction_vld), 128'(1));
        checkOutput("t3_rs2", 128'(instruction_pld.reg_rs2_val), 128'(32'h42));
        tick();
        checkOutput("t3_count_after", 128'(iq_count), 128'(0));

        // Younger ready entry overtakes an older waiting one.
        $display("[TB] oldest-ready select");
        applyStimulus(4'h4, 1'b0, 6'd3, 32'h0, 1'b1, 6'd5, 32'h20);
        tick();
        checkOutput("t4_a_wait", 128'(instruction_vld), 128'(0));
        applyStimulus(4'h5, 1'b1, 6'd6, 32'h1, 1'b1, 6'd8, 32'h2);
        expQ.push_back(mkPld(4'h5, 32'h1, 32'h2));
        tick();
        enq_vld = 1'b0;
        checkOutput("t4_b_sel", 128'(instruction_pld.opcode), 128'(4'h5));
        tick();
        checkOutput("t4_count_a", 128'(iq_count), 128'(1));
        wb0_en = 1'b1; wb0_index = 6'd3; wb0_data = 32'h30;
        expQ.push_back(mkPld(4'h4, 32'h30, 32'h20));
        tick();
        wb0_en = 1'b0;
        checkOutput("t4_a_ivld", 128'(instruction_vld), 128'(1));
        tick();
        instruction_rdy = 1'b0;
        applyStimulus(4'h6, 1'b1, 6'd1, 32'h61, 1'b1, 6'd1, 32'h62);
        tick();
        applyStimulus(4'h7, 1'b1, 6'd1, 32'h71, 1'b1, 6'd1, 32'h72);
        tick();
        enq_vld = 1'b0;
        expQ.push_back(mkPld(4'h6, 32'h61, 32'h62));
        expQ.push_back(mkPld(4'h7, 32'h71, 32'h72));
        instruction_rdy = 1'b1;
        tick();
        tick();
        checkOutput("t4_count_after", 128'(iq_count), 128'(0));

        // Issue, enqueue and wakeup together; the shifted entry keeps its wakeup.
        $display("[TB] simultaneous issue/enqueue/wakeup");
        instruction_rdy = 1'b0;
        applyStimulus(4'h8, 1'b1, 6'd1, 32'h8, 1'b1, 6'd1, 32'h8);
        tick();
        applyStimulus(4'h9, 1'b1, 6'd1, 32'h1, 1'b0, 6'd9, 32'h0);
        tick();
        enq_vld = 1'b0;
        checkOutput("t5_count", 128'(iq_count), 128'(2));
        instruction_rdy = 1'b1;
        applyStimulus(4'hA, 1'b1, 6'd1, 32'hA, 1'b1, 6'd1, 32'hA);
        wb0_en = 1'b1; wb0_index = 6'd9; wb0_data = 32'h99;
        expQ.push_back(mkPld(4'h8, 32'h8, 32'h8));
        expQ.push_back(mkPld(4'h9, 32'h1, 32'h99));
        expQ.push_back(mkPld(4'hA, 32'hA, 32'hA));
        tick();
        enq_vld = 1'b0; wb0_en = 1'b0;
        checkOutput("t5_count_mid", 128'(iq_count), 128'(2));
        checkOutput("t5_shift_rs2", 128'(instruction_pld.reg_rs2_val), 128'(32'h99));
        tick();
        tick();
        checkOutput("t5_count_after", 128'(iq_count), 128'(0));

        // Full queue refuses enqueue even in a cycle that issues.
        $display("[TB] fill to capacity");
        instruction_rdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'(k), 1'b1, 6'd1, 32'(k + 100), 1'b1, 6'd2, 32'(k + 200));
            expQ.push_back(mkPld(4'(k), 32'(k + 100), 32'(k + 200)));
            tick();
        end
        enq_vld = 1'b0;
        checkOutput("t6_full_enq_rdy", 128'(enq_rdy), 128'(0));
        checkOutput("t6_full_count", 128'(iq_count), 128'(8));
        instruction_rdy = 1'b1;
        applyStimulus(4'hF, 1'b1, 6'd1, 32'hF, 1'b1, 6'd1, 32'hF);
        tick();
        enq_vld = 1'b0;
        checkOutput("t6_count_7", 128'(iq_count), 128'(7));
        checkOutput("t6_enq_rdy", 128'(enq_rdy), 128'(1));
        for (int k = 0; k < 30 && !iq_empty; k++) begin
            tick();
        end
        checkOutput("t6_drained", 128'(iq_count), 128'(0));

        // Flush wins over a concurrent enqueue.
        $display("[TB] flush");
        instruction_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'hC, 1'b1, 6'd1, 32'(k), 1'b1, 6'd1, 32'(k));
            tick();
        end
        enq_vld = 1'b0;
        checkOutput("t7_count_5", 128'(iq_count), 128'(5));
        flush = 1'b1;
        applyStimulus(4'hE, 1'b1, 6'd1, 32'hE, 1'b1, 6'd1, 32'hE);
        tick();
        flush = 1'b0; enq_vld = 1'b0;
        checkOutput("t7_count", 128'(iq_count), 128'(0));
        checkOutput("t7_empty", 128'(iq_empty), 128'(1));
        checkOutput("t7_ivld", 128'(instruction_vld), 128'(0));
        instruction_rdy = 1'b1;
        repeat (3) tick();
        checkOutput("t7_dropped", 128'(iq_count), 128'(0));

        checkOutput("sb_drained", 128'(expQ.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
